lea_key_scheduler: RTL and testbench

//   Iterative LEA key schedule: accepts a 128/192/256-bit master key and emits
//   one 192-bit round key per cycle (RK0..RK[NR-1]) over a valid/ready stream.

---
 rtl/lea_key_scheduler_if.sv | 32 +++
 rtl/lea_key_scheduler.sv | 140 ++++++++++++++
 tb/tb_lea_key_scheduler.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lea_key_scheduler_if.sv
// Handshake bundle between the LEA key scheduler and its neighbours.
//   key_valid/key_ready/key_in : master key stream into the scheduler
//   abort                      : drop the schedule in progress
//   rk_valid/rk_ready/rk_out   : round key stream out of the scheduler
//   rk_idx/rk_last             : round index of rk_out, last-round flag
//   busy                       : schedule in progress
// slave  = scheduler side, master = key source / round datapath side.
interface lea_key_scheduler_if #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned RK_BITS  = 192
);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_in;
  logic                abort;
  logic                rk_valid;
  logic                rk_ready;
  logic [RK_BITS-1:0]  rk_out;
  logic [4:0]          rk_idx;
  logic                rk_last;
  logic                busy;

  modport master (
    output key_valid, key_in, abort, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );

  modport slave (
    input  key_valid, key_in, abort, rk_ready,
    output key_ready, rk_valid, rk_out, rk_idx, rk_last, busy
  );
endinterface

// File: rtl/lea_key_scheduler.sv
// Iterative LEA key schedule. Accepts a 128/192/256-bit master key and emits
// one 192-bit round key per cycle (RK0..RK[NR-1]) over a valid/ready stream.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : lea_key_scheduler_if.slave (key stream in, round key stream out,
//            abort, busy)
module lea_key_scheduler #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned RK_BITS  = 192
) (
  input  logic              clk,
  input  logic              rst_n,
  lea_key_scheduler_if.slave bus
);

  localparam int unsigned NW       = KEY_BITS / 32;
  localparam int unsigned NR       = (KEY_BITS == 128) ? 24 : (KEY_BITS == 192) ? 28 : 32;
  localparam int unsigned NSTEP    = (KEY_BITS == 128) ? 4 : 6;
  localparam logic [4:0]  LAST_IDX = 5'(NR - 1);

  localparam logic [7:0][31:0] DELTA = {
    32'he5c40957, 32'he04ef22a, 32'hc785da0a, 32'h715ea49e,
    32'h78df30ec, 32'h79e27c8a, 32'h44626b02, 32'hc3efe9db
  };
  localparam logic [5:0][4:0] ROT = {5'd17, 5'd13, 5'd11, 5'd6, 5'd3, 5'd1};

  generate
    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
      $error("lea_key_scheduler: KEY_BITS must be 128, 192 or 256");
    end
    if (RK_BITS != 192) begin : g_bad_rk_bits
      $error("lea_key_scheduler: RK_BITS must be 192");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    GEN
  } state_t;

  state_t              state_q, state_d;
  logic                load, adv;
  logic [KEY_BITS-1:0] t_q, t_nxt;
  logic [RK_BITS-1:0]  rk_q, rk_nxt;
  logic [4:0]          idx_q, src_i;
  logic [7:0][31:0]    w_src, w_nxt;
  logic [5:0][31:0]    rk_w;
  logic [31:0]         d;
  logic [2:0]          k;

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  // One round of the schedule. The working set is always eight words wide so
  // that every key size shares one datapath; unused upper words stay zero.
  // In IDLE the round is computed straight from key_in so RK0 is registered
  // on the key handshake itself.
  always_comb begin
    w_src          = '0;
    w_src[NW-1:0]  = (state_q == IDLE) ? bus.key_in : t_q;
    src_i          = (state_q == IDLE) ? 5'd0 : idx_q + 5'd1;
    d              = DELTA[3'(32'(src_i) % NW)];
    w_nxt          = w_src;
    rk_w           = '0;
    k              = '0;
    // 256-bit keys walk a ring of eight words, six per round; six consecutive
    // indices mod 8 are distinct, so all updates read only pre-round values.
    for (int unsigned j = 0; j < NSTEP; j++) begin
      k        = (KEY_BITS == 256) ? 3'(32'(src_i) * 6 + j) : 3'(j);
      w_nxt[k] = rol32(w_src[k] + rol32(d, src_i + 5'(j)), ROT[3'(j)]);
    end
    if (KEY_BITS == 128) begin
      rk_w = {w_nxt[1], w_nxt[3], w_nxt[1], w_nxt[2], w_nxt[1], w_nxt[0]};
    end else if (KEY_BITS == 192) begin
      rk_w = w_nxt[5:0];
    end else begin
      for (int unsigned j = 0; j < 6; j++) begin
        rk_w[j] = w_nxt[3'(32'(src_i) * 6 + j)];
      end
    end
    t_nxt  = w_nxt[NW-1:0];
    rk_nxt = rk_w;
  end

  // Abort beats both a same-cycle round key handshake and, in IDLE, a key
  // handshake.
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    adv           = 1'b0;
    bus.key_ready = rst_n && (state_q == IDLE);
    bus.rk_valid  = (state_q == GEN);
    bus.busy      = (state_q == GEN);
    bus.rk_last   = (state_q == GEN) && (idx_q == LAST_IDX);
    bus.rk_out    = rk_q;
    bus.rk_idx    = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.key_valid && !bus.abort) begin
          state_d = GEN;
          load    = 1'b1;
        end
      end
      GEN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q   <= '0;
      rk_q  <= '0;
      idx_q <= '0;
    end else if (load || adv) begin
      t_q   <= t_nxt;
      rk_q  <= rk_nxt;
      idx_q <= load ? 5'd0 : idx_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_lea_key_scheduler.sv
// Self-checking bench for lea_key_scheduler: one instance per key size,
// round keys compared against a sequential reference of the LEA key schedule.
module tb_lea_key_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Index 0/1/2 = 128/192/256-bit instance.
  logic         kv [3];
  logic         ab [3];
  logic         rr [3];
  logic [255:0] key[3];
  logic         kr [3];
  logic         rv [3];
  logic         rl [3];
  logic         by [3];
  logic [191:0] ro [3];
  logic [4:0]   rix[3];

  logic [191:0] exp_rk [32];

  localparam logic [31:0] DL [8] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
                                     32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957};
  localparam int RR [6] = '{1, 3, 6, 11, 13, 17};

  lea_key_scheduler_if #(.KEY_BITS(128)) if128 ();
  lea_key_scheduler_if #(.KEY_BITS(192)) if192 ();
  lea_key_scheduler_if #(.KEY_BITS(256)) if256 ();

  lea_key_scheduler #(.KEY_BITS(128)) dut128 (.clk(clk), .rst_n(rst_n), .bus(if128));
  lea_key_scheduler #(.KEY_BITS(192)) dut192 (.clk(clk), .rst_n(rst_n), .bus(if192));
  lea_key_scheduler #(.KEY_BITS(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

  assign if128.key_valid = kv[0];
  assign if128.key_in    = key[0][127:0];
  assign if128.abort     = ab[0];
  assign if128.rk_ready  = rr[0];
  assign kr[0]  = if128.key_ready;
  assign rv[0]  = if128.rk_valid;
  assign rl[0]  = if128.rk_last;
  assign by[0]  = if128.busy;
  assign ro[0]  = if128.rk_out;
  assign rix[0] = if128.rk_idx;

  assign if192.key_valid = kv[1];
  assign if192.key_in    = key[1][191:0];
  assign if192.abort     = ab[1];
  assign if192.rk_ready  = rr[1];
  assign kr[1]  = if192.key_ready;
  assign rv[1]  = if192.rk_valid;
  assign rl[1]  = if192.rk_last;
  assign by[1]  = if192.busy;
  assign ro[1]  = if192.rk_out;
  assign rix[1] = if192.rk_idx;

  assign if256.key_valid = kv[2];
  assign if256.key_in    = key[2];
  assign if256.abort     = ab[2];
  assign if256.rk_ready  = rr[2];
  assign kr[2]  = if256.key_ready;
  assign rv[2]  = if256.rk_valid;
  assign rl[2]  = if256.rk_last;
  assign by[2]  = if256.busy;
  assign ro[2]  = if256.rk_out;
  assign rix[2] = if256.rk_idx;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int kbits(input int s);
    return 128 + 64 * s;
  endfunction

  function automatic int nrounds(input int s);
    return 24 + 4 * s;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} << (n % 32);
    return y[63:32];
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference key schedule, round by round, straight from the LEA rules.
  task automatic build_ref(input int s, input logic [255:0] k);
    logic [31:0] t [8];
    logic [31:0] dd;
    int kb, nw, idx;
    kb = kbits(s);
    nw = kb / 32;
    for (int j = 0; j < 8; j++) t[j] = (j < nw) ? k[32*j +: 32] : 32'h0;
    for (int i = 0; i < nrounds(s); i++) begin
      dd = DL[i % nw];
      if (kb == 256) begin
        for (int j = 0; j < 6; j++) begin
          idx = (6 * i + j) % 8;
          t[idx] = rol(t[idx] + rol(dd, i + j), RR[j]);
          exp_rk[i][32*j +: 32] = t[idx];
        end
      end else begin
        for (int j = 0; j < ((kb == 128) ? 4 : 6); j++) begin
          t[j] = rol(t[j] + rol(dd, i + j), RR[j]);
        end
        if (kb == 128) exp_rk[i] = {t[1], t[3], t[1], t[2], t[1], t[0]};
        else           exp_rk[i] = {t[5], t[4], t[3], t[2], t[1], t[0]};
      end
    end
  endtask

  // Runs one full schedule on instance s; entered and left at #1 after a posedge.
  task automatic run_sched(input int s, input logic [255:0] k, input int stall_pct, input bit hold_kv);
    int    nr, got_n, budget;
    bit    take;
    string tg;
    nr = nrounds(s);
    build_ref(s, k);
    tg = $sformatf("k%0d", kbits(s));
    budget = 0;
    while (kr[s] !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check({tg, " key_ready idle"}, 192'(kr[s]), 192'(1));
    if (hold_kv) check({tg, " back-to-back gap"}, 192'(budget), 192'(0));
    kv[s]  = 1'b1;
    key[s] = k;
    @(posedge clk); #1;
    if (!hold_kv) kv[s] = 1'b0;
    got_n  = 0;
    budget = 0;
    while (got_n < nr && budget < 400) begin
      check({tg, " rk_valid"}, 192'(rv[s]), 192'(1));
      if (rv[s] !== 1'b1) break;
      check($sformatf("%s rk_idx@%0d", tg, got_n), 192'(rix[s]), 192'(got_n));
      check($sformatf("%s rk_out@%0d", tg, got_n), ro[s], exp_rk[got_n]);
      check($sformatf("%s rk_last@%0d", tg, got_n), 192'(rl[s]), 192'(got_n == nr - 1));
      check({tg, " busy"}, 192'(by[s]), 192'(1));
      check({tg, " key_ready gen"}, 192'(kr[s]), 192'(0));
      take  = ($urandom_range(99) >= 32'(stall_pct));
      rr[s] = take;
      if (hold_kv) key[s] = rand_key();
      @(posedge clk); #1;
      budget++;
      if (take) got_n++;
    end
    rr[s] = 1'b0;
    check({tg, " keys delivered"}, 192'(got_n), 192'(nr));
    check({tg, " rk_valid after last"}, 192'(rv[s]), 192'(0));
    check({tg, " key_ready after last"}, 192'(kr[s]), 192'(1));
  endtask

  task automatic abort_test();
    build_ref(0, '0);
    kv[0]  = 1'b1;
    key[0] = '0;
    rr[0]  = 1'b1;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    check("zero key rk0 word0", 192'(ro[0][31:0]), 192'(32'h87dfd3b7));
    check("zero key rk0 word1", 192'(ro[0][63:32]), 192'(32'h3efe9dbc));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort run rk_out@%0d", i), ro[0], exp_rk[i]);
      @(posedge clk); #1;
    end
    check("abort run rk_idx", 192'(rix[0]), 192'(5));
    check("abort run rk5", ro[0], exp_rk[5]);
    ab[0] = 1'b1;
    @(posedge clk); #1;
    ab[0] = 1'b0;
    rr[0] = 1'b0;
    check("abort rk_valid", 192'(rv[0]), 192'(0));
    check("abort rk_out hold", ro[0], exp_rk[5]);
    check("abort busy", 192'(by[0]), 192'(0));
    check("abort key_ready", 192'(kr[0]), 192'(1));
    @(posedge clk); #1;
    check("abort no rk6", 192'(rv[0]), 192'(0));
  endtask

  task automatic abort_idle_test();
    kv[0]  = 1'b1;
    ab[0]  = 1'b1;
    key[0] = rand_key();
    @(posedge clk); #1;
    kv[0] = 1'b0;
    ab[0] = 1'b0;
    check("idle abort rk_valid", 192'(rv[0]), 192'(0));
    check("idle abort key_ready", 192'(kr[0]), 192'(1));
  endtask

  task automatic reset_test();
    kv[0]  = 1'b1;
    key[0] = rand_key();
    rr[0]  = 1'b1;
    @(posedge clk); #1;
    kv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre-reset rk_valid", 192'(rv[0]), 192'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid reset rk_valid", 192'(rv[0]), 192'(0));
    check("mid reset rk_out", ro[0], 192'(0));
    check("mid reset rk_idx", 192'(rix[0]), 192'(0));
    check("mid reset rk_last", 192'(rl[0]), 192'(0));
    check("mid reset busy", 192'(by[0]), 192'(0));
    check("mid reset key_ready", 192'(kr[0]), 192'(0));
    rst_n = 1'b1;
    rr[0] = 1'b0;
    @(posedge clk); #1;
    check("post reset key_ready", 192'(kr[0]), 192'(1));
    check("post reset rk_valid", 192'(rv[0]), 192'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] kat [3];
    kat[0] = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    kat[1] = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0f0e1d2c3b4a59687;
    kat[2] = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f0f0e1d2c3b4a5968778695a4b3c2d1e0f;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      kv[s]  = 1'b0;
      ab[s]  = 1'b0;
      rr[s]  = 1'b0;
      key[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset rk_valid %0d", s), 192'(rv[s]), 192'(0));
      check($sformatf("reset rk_out %0d", s), ro[s], 192'(0));
      check($sformatf("reset rk_idx %0d", s), 192'(rix[s]), 192'(0));
      check($sformatf("reset rk_last %0d", s), 192'(rl[s]), 192'(0));
      check($sformatf("reset busy %0d", s), 192'(by[s]), 192'(0));
      check($sformatf("reset key_ready %0d", s), 192'(kr[s]), 192'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("release key_ready %0d", s), 192'(kr[s]), 192'(1));
    end

    abort_test();
    run_sched(0, rand_key(), 0, 1'b0);
    abort_idle_test();

    for (int s = 0; s < 3; s++) begin
      run_sched(s, kat[s], 0, 1'b0);
      run_sched(s, kat[s], 30, 1'b0);
      run_sched(s, rand_key(), 30, 1'b0);
    end

    run_sched(2, rand_key(), 30, 1'b1);
    run_sched(2, rand_key(), 0, 1'b1);
    kv[2] = 1'b0;
    run_sched(0, rand_key(), 0, 1'b1);
    run_sched(0, rand_key(), 30, 1'b1);
    kv[0] = 1'b0;

    reset_test();
    run_sched(0, rand_key(), 30, 1'b0);
    run_sched(1, rand_key(), 30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
